datamemory_ctrl: RTL

//  Byte-addressable MIPS data memory with a request/response handshake.

---
 rtl/datamemory_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/datamemory_ctrl.sv
// ----------------------------------------------------------------------------
// datamemory_ctrl
//   Byte-addressable MIPS data memory behind a request/response handshake.
//   Handles LB/LBU/LH/LHU/LW and SB/SH/SW. Stores use byte-lane enables.
//   Loads are shifted to the LSBs and sign- or zero-extended. Misaligned
//   accesses and the illegal size code return an error response. Only one
//   access is outstanding at a time.
//
// Parameters
//   ADDR_WIDTH    word-address bits; the array holds 1<<ADDR_WIDTH words
//   DATA_WIDTH    word width; fixed at 32 (four byte lanes)
//   READ_LATENCY  cycles from the accept edge to rsp_valid for loads (1..4)
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     block can accept; a transfer happens when valid&ready
//                   are both high at a rising edge
//   req_we_i        0 = load, 1 = store
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr_i      byte address
//   req_wdata_i     store data, right-justified
//   rsp_valid_o     one-cycle pulse when the access completes
//   rsp_rdata_o     extended load data; 0 for stores and errors
//   rsp_err_o       misaligned or illegal size; valid with rsp_valid_o
//
// Timing
//   rsp_valid_o is high in the cycle that starts RESP-1 edges after the
//   accept edge, so a consumer samples it on edge accept+latency. Loads
//   have a latency of READ_LATENCY. Stores and errors have a latency of 1.
//   req_ready_o is low while a request is in flight. It is also low during
//   the response cycle. The next request is taken on the edge that ends the
//   response cycle's successor.
// ----------------------------------------------------------------------------
module datamemory_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The counter holds the remaining BUSY cycles for a load.
  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_off;
  logic                  req_err;
  logic                  accept;
  logic                  wr_en;

  assign word_idx = req_addr_i[ADDR_WIDTH+1:2];
  assign byte_off = req_addr_i[1:0];

  // A halfword must be 2-byte aligned and a word must be 4-byte aligned.
  // Size code 11 is never legal.
  assign req_err = (req_size_i == 2'b11)
                 | ((req_size_i == SZ_HALF) & byte_off[0])
                 | ((req_size_i == SZ_WORD) & (byte_off != 2'b00));

  assign accept = req_valid_i & req_ready_o;
  assign wr_en  = accept & req_we_i & ~req_err;

  // --------------------------------------------------------------------------
  // Byte-lane enables and lane-replicated store data.
  // A byte or halfword is copied into every lane it could occupy, so the
  // enable pattern alone decides which lanes get written.
  // --------------------------------------------------------------------------
  logic [NUM_LANES-1:0]  be;
  logic [DATA_WIDTH-1:0] wdata_lanes;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);

    assign be[gi] = (req_size_i == SZ_BYTE) ? (byte_off == LANE) :
                    (req_size_i == SZ_HALF) ? (byte_off[1] == LANE[1]) :
                    (req_size_i == SZ_WORD);

    assign wdata_lanes[gi*8 +: 8] =
        (req_size_i == SZ_BYTE) ? req_wdata_i[7:0] :
        (req_size_i == SZ_HALF) ? req_wdata_i[(gi % 2)*8 +: 8] :
                                  req_wdata_i[gi*8 +: 8];
  end

  // --------------------------------------------------------------------------
  // Word array. It is never reset. Power-up contents come from the
  // declaration.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{
    0:       DATA_WIDTH'(2001),
    1:       DATA_WIDTH'(4001),
    2:       DATA_WIDTH'(5001),
    3:       DATA_WIDTH'(3001),
    default: '0
  };
  logic [DATA_WIDTH-1:0] rd_word_q;

  // The write and the read both happen on the accept edge.
  // The read returns the old word, but loads never write, so this is safe.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) begin
          mem_q[word_idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
        end
      end
    end
    if (accept) begin
      rd_word_q <= mem_q[word_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       rsp_valid_q, rsp_valid_d;

  // Fields captured at the accept edge. They shape the response and hold
  // until the next accept.
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [1:0] offset_q;
  logic       err_q;
  logic       load_ok_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Only a load longer than one cycle needs to wait in BUSY.
          if (!req_we_i && !req_err && (READ_LATENCY > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        // Leave BUSY on the cycle in which the counter reaches zero.
        if (cnt_q <= 2'd1) begin
          state_d = RESP;
        end
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Both outputs are registered straight from the next state.
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // ready_q is cleared by reset. It only rises on the first edge after
  // reset is released, so nothing is accepted while reset is active.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      err_q       <= 1'b0;
      load_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        size_q     <= req_size_i;
        unsigned_q <= req_unsigned_i;
        offset_q   <= byte_off;
        err_q      <= req_err;
        load_ok_q  <= ~req_we_i & ~req_err;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load data: shift the addressed lane(s) down to the LSBs, then extend.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] extended;

  assign shifted = rd_word_q >> {offset_q, 3'b000};

  always_comb begin
    extended = shifted;
    unique case (size_q)
      SZ_BYTE: extended = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                     : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: extended = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                     : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: extended = shifted;  // a word ignores req_unsigned
    endcase
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = load_ok_q ? extended : '0;
  assign rsp_err_o   = err_q;

endmodule
